// File: rtl/rr_bus_arbiter_pkg.sv
// Purpose  : shared constants and bit-vector helpers for the round-robin bus arbiter.
// Latency  : n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   MAX_N          widest requester vector the helpers handle
//   PARK_IDX       master that owns the bus after reset
//   rotate_right   bit-rotate within the low n bits, bit sh lands at position 0
//   rotate_left    inverse of rotate_right
//   onehot_to_idx  binary index of the set bit of a one-hot vector
package arb_pkg;

  localparam int MAX_N    = 32;
  localparam int PARK_IDX = 0;

  typedef logic [MAX_N-1:0] vec_t;
  // Index arithmetic type: wide enough to hold i + sh before the wrap (< 2*MAX_N).
  typedef logic [5:0]       cnt_t;

  // Rotate the low n bits of v right by sh (sh < n): result[i] = v[(i + sh) mod n].
  // Bits at or above n are returned as zero.
  function automatic vec_t rotate_right(input vec_t v, input cnt_t sh, input cnt_t n);
    vec_t r;
    cnt_t j;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      j = cnt_t'(i) + sh;
      if (j >= n) j = j - n;
      if (cnt_t'(i) < n) r[i] = v[j[4:0]];
    end
    return r;
  endfunction

  // Rotate the low n bits of v left by sh (sh < n): result[(i + sh) mod n] = v[i].
  function automatic vec_t rotate_left(input vec_t v, input cnt_t sh, input cnt_t n);
    vec_t r;
    cnt_t j;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      j = cnt_t'(i) + sh;
      if (j >= n) j = j - n;
      if (cnt_t'(i) < n) r[j[4:0]] = v[i];
    end
    return r;
  endfunction

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic logic [4:0] onehot_to_idx(input vec_t v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Purpose  : request/grant bundle between the bus masters and the arbiter.
// Latency  : n/a (wires only).
// Backpressure: none; req is level-sensitive and held until grant_valid is seen.
//
// Signals:
//   req[N]       per-master request
//   lock[N]      per-master lock request (honoured only in ARB_LOCK_EN builds)
//   grant[N]     one-hot grant, drives the bus mux select
//   grant_id     binary index of the granted master
//   grant_valid  granted master was requesting at the last edge
// Modports: master = requester side, slave = arbiter side.
interface rr_bus_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int ID_W      = $clog2(N_MASTERS)
);

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] lock;
  logic [N_MASTERS-1:0] grant;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_valid;

  modport master (
    output req,
    output lock,
    input  grant,
    input  grant_id,
    input  grant_valid
  );

  modport slave (
    input  req,
    input  lock,
    output grant,
    output grant_id,
    output grant_valid
  );

endinterface

// File: rtl/rr_bus_arbiter_pick.sv
// Purpose  : combinational round-robin pick of the first requester after the current owner.
// Latency  : 0 cycles (pure combinational).
// Backpressure: n/a.
//
// Ports:
//   others[N]  requests with the current owner already masked off
//   cur        index of the current owner
//   winner[N]  one-hot first set bit of others searching cur+1, cur+2, ... (wrapping);
//              all-zero when others is zero
module rr_pick
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    others,
  input  logic [ID_W-1:0] cur,
  output logic [N-1:0]    winner
);

  cnt_t         sh;
  logic [N-1:0] rot;
  logic [N-1:0] first;

  always_comb begin
    // Rotating by cur+1 puts the highest-priority candidate at bit 0, so a
    // plain lowest-set-bit encoder yields the round-robin winner.
    sh    = (cnt_t'(cur) == cnt_t'(N - 1)) ? cnt_t'(0) : cnt_t'(cur) + cnt_t'(1);
    rot   = N'(rotate_right(vec_t'(others), sh, cnt_t'(N)));
    first = rot & (~rot + N'(1));
    winner = N'(rotate_left(vec_t'(first), sh, cnt_t'(N)));
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Purpose  : N-master round-robin bus arbiter with per-grant tenure limit.
// Latency  : req sampled at edge t, new grant/grant_id/grant_valid visible after edge t;
//            no combinational path from req to any output.
// Backpressure: none; masters hold req (level) until they see their grant with grant_valid.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    rr_bus_arbiter_if.slave (req, lock in; grant, grant_id, grant_valid out)
// Build option: ARB_LOCK_EN - when defined, an owner asserting lock and req is never
//   force-rotated by the tenure limit. When undefined the lock inputs are ignored.
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int N_MASTERS  = 4,
  parameter int MAX_TENURE = 8,
  parameter int ID_W       = $clog2(N_MASTERS)
) (
  input  logic              clk,
  input  logic              reset,
  rr_bus_arbiter_if.slave   bus
);

  // Tenure counter sized for 0..MAX_TENURE; unlimited tenure keeps a 1-bit
  // counter parked at zero.
  localparam int TEN_W   = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
  localparam int TEN_LIM = (MAX_TENURE > 0) ? MAX_TENURE - 1 : 0;
  localparam logic [N_MASTERS-1:0] PARK_GRANT = N_MASTERS'(1) << PARK_IDX;

  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [TEN_W-1:0]     tenure_q, tenure_d;
  logic                 valid_q, valid_d;

  logic [N_MASTERS-1:0] others;
  logic [N_MASTERS-1:0] winner;
  logic                 owner_req;
  logic                 tenure_sat;
  logic                 lock_hold;

  assign others     = bus.req & ~grant_q;
  assign owner_req  = |(bus.req & grant_q);
  // Saturated means the owner has used its last allowed cycle.
  assign tenure_sat = (MAX_TENURE != 0) && (tenure_q >= TEN_W'(TEN_LIM));

`ifdef ARB_LOCK_EN
  // Only the owner's lock counts, and only while it is still requesting.
  assign lock_hold = |(bus.lock & bus.req & grant_q);
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign lock_hold   = 1'b0;
`endif

  rr_pick #(
    .N    (N_MASTERS),
    .ID_W (ID_W)
  ) u_pick (
    .others (others),
    .cur    (grant_id_q),
    .winner (winner)
  );

  always_comb begin
    grant_d  = grant_q;
    tenure_d = tenure_q;
    if (bus.req == '0) begin
      // Idle bus: park on the current owner and forget its tenure.
      tenure_d = '0;
    end else if (owner_req &&
                 (others == '0 || MAX_TENURE == 0 || !tenure_sat || lock_hold)) begin
      // Owner keeps the bus; the counter climbs but never passes the limit.
      if (MAX_TENURE != 0 && !tenure_sat) tenure_d = tenure_q + TEN_W'(1);
    end else begin
      // Owner dropped req, or its tenure ran out while others wait.
      grant_d  = winner;
      tenure_d = '0;
    end
    grant_id_d = ID_W'(onehot_to_idx(vec_t'(grant_d)));
    valid_d    = |(bus.req & grant_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q    <= PARK_GRANT;
      grant_id_q <= ID_W'(PARK_IDX);
      tenure_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      tenure_q   <= tenure_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter with N_MASTERS=4, MAX_TENURE=4.
// Expected grants are hand-derived: after the k-th edge of a fully requested
// stretch the owner is (start + k/4) mod 4, where the owner's pre-stretch cycle is k=0.
module tb_rr_bus_arbiter;

  localparam int N = 4;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  rr_bus_arbiter_if #(.N_MASTERS(N), .ID_W(2)) bus ();

  rr_bus_arbiter #(
    .N_MASTERS  (N),
    .MAX_TENURE (T),
    .ID_W       (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      assert (!$isunknown(bus.req)) else begin
        errors++;
        $error("FAIL req_known observed=%b expected=no X", bus.req);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] oh(input int idx);
    return 32'd1 << idx;
  endfunction

  task automatic chk_owner(input string tag, input int owner, input logic vld);
    chk({tag, "_grant"}, 32'(bus.grant), oh(owner));
    chk({tag, "_id"},    32'(bus.grant_id), 32'(owner));
    chk({tag, "_vld"},   32'(bus.grant_valid), 32'(vld));
  endtask

  initial begin
    int exp_owner;

    // Reset state, then idle parking on master 0.
    reset    = 1'b1;
    bus.req  = '0;
    bus.lock = '0;
    tick();
    tick();
    chk_owner("reset", 0, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_owner($sformatf("idle%0d", k), 0, 1'b0);
    end

    // All masters requesting: T cycles each in ascending cyclic order.
    bus.req = 4'b1111;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk_owner($sformatf("rot%0d", k), (k / T) % N, 1'b1);
    end

    // Owner 2 drops; 3 comes before 0 in the wrap order.
    bus.req = 4'b1001;
    tick();
    chk_owner("wrap", 3, 1'b1);

    // Lone requester keeps the bus indefinitely.
    bus.req = 4'b0010;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk_owner($sformatf("solo%0d", k), 1, 1'b1);
    end

    // Saturated owner 1 rotates immediately once others ask; reach owner 3.
    bus.req = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_owner($sformatf("pre_rst%0d", k), (k <= 4) ? 2 : 3, 1'b1);
    end

    // One-cycle reset mid-rotation, then rotation resumes from master 0.
    reset = 1'b1;
    tick();
    chk_owner("mid_rst", 0, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_owner($sformatf("post_rst%0d", k), (k / T) % N, 1'b1);
    end

    // Master 1 owns with lock; only lock-enabled builds suppress rotation.
    bus.lock = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef ARB_LOCK_EN
      exp_owner = 1;
`else
      exp_owner = (1 + k / T) % N;
`endif
      chk_owner($sformatf("lock%0d", k), exp_owner, 1'b1);
    end

    // Master 1 drops req: a held lock releases at once.
    bus.req = 4'b1101;
    tick();
`ifdef ARB_LOCK_EN
    exp_owner = 2;
`else
    exp_owner = 0;
`endif
    chk_owner("unlock", exp_owner, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
